// File: rtl/mant_mul24_seq.sv
// Iterative 24x24 unsigned mantissa multiplier for the FP32 multiply path.
// One shared 16x16 Karatsuba multiplier is fed four partial products over four cycles.

module Karatsuba16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  logic [7:0]  w_aLo, w_aHi, w_bLo, w_bHi;
  logic [15:0] w_z0, w_z2;
  logic [8:0]  w_aSum, w_bSum;
  logic [17:0] w_zMid, w_z1;

  assign w_aLo  = i_a[7:0];
  assign w_aHi  = i_a[15:8];
  assign w_bLo  = i_b[7:0];
  assign w_bHi  = i_b[15:8];
  assign w_z0   = {8'b0, w_aLo} * {8'b0, w_bLo};
  assign w_z2   = {8'b0, w_aHi} * {8'b0, w_bHi};
  assign w_aSum = {1'b0, w_aLo} + {1'b0, w_aHi};
  assign w_bSum = {1'b0, w_bLo} + {1'b0, w_bHi};
  assign w_zMid = {9'b0, w_aSum} * {9'b0, w_bSum};
  // Middle term (aLo*bHi + aHi*bLo) recovered from one multiply of the half sums.
  assign w_z1   = w_zMid - {2'b0, w_z0} - {2'b0, w_z2};
  assign o_p    = {w_z2, w_z0} + {6'b0, w_z1, 8'b0};
endmodule

module mant_mul24_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] product
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      r_state, w_nextState;
  logic [1:0]  r_step;
  logic [23:0] r_a, r_b;
  logic [47:0] r_acc;
  logic [15:0] w_mulA, w_mulB;
  logic [31:0] w_mulP;
  logic [47:0] w_pp;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && in_valid;

  // step[1] picks the high half of A, step[0] the high half of B.
  assign w_mulA = r_step[1] ? {8'b0, r_a[23:16]} : r_a[15:0];
  assign w_mulB = r_step[0] ? {8'b0, r_b[23:16]} : r_b[15:0];

  Karatsuba16bit u_mul (
    .i_a (w_mulA),
    .i_b (w_mulB),
    .o_p (w_mulP)
  );

  always_comb begin
    w_pp = 48'b0;
    case (r_step)
      2'd0:    w_pp = {16'b0, w_mulP};
      2'd1,
      2'd2:    w_pp = {w_mulP, 16'b0};
      default: w_pp = {w_mulP[15:0], 32'b0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = MUL;
      end
      MUL: begin
        if (r_step == 2'd3) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= 24'b0;
      r_b    <= 24'b0;
      r_step <= 2'd0;
      r_acc  <= 48'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_step <= 2'd0;
      r_acc  <= 48'b0;
    end else if (r_state == MUL) begin
      r_acc  <= r_acc + w_pp;
      r_step <= r_step + 2'd1;
    end
  end

  assign product = r_acc;
endmodule

// File: tb/tb_mant_mul24_seq.sv
// Directed and randomized checks of mant_mul24_seq against a plain a*b reference
// with a queue of expected products.

module tb_mant_mul24_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a = 24'b0;
  logic [23:0] b = 24'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] product;

  int nChecks = 0;
  int nErrors = 0;
  logic [47:0] expQ[$];

  mant_mul24_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] refMul(input logic [23:0] x, input logic [23:0] y);
    return {24'b0, x} * {24'b0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand pair from IDLE and return after the accepting edge.
  task automatic applyStimulus(input logic [23:0] aV, input logic [23:0] bV);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("in_ready_before_accept", {47'b0, in_ready}, 48'd1);
    a = aV;
    b = bV;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expQ.push_back(refMul(aV, bV));
  endtask

  // Cycles from the accepting edge until out_valid is seen.
  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic completeHandshake(input string tag);
    logic [47:0] expP;
    expP = (expQ.size() > 0) ? expQ.pop_front() : 48'hDEAD_DEAD_DEAD;
    checkOutput({tag, "_product"}, product, expP);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_drop"}, {47'b0, out_valid}, 48'd0);
    checkOutput({tag, "_in_ready_back"}, {47'b0, in_ready}, 48'd1);
  endtask

  task automatic runDirected(input string tag, input logic [23:0] aV, input logic [23:0] bV,
                             input logic [47:0] expP);
    int lat;
    applyStimulus(aV, bV);
    waitValid(lat);
    checkOutput({tag, "_latency"}, 48'(lat), 48'd4);
    checkOutput({tag, "_const"}, product, expP);
    completeHandshake(tag);
  endtask

  initial begin
    int lat;
    logic [47:0] held;
    logic [23:0] ra, rb;
    bit done;

    // Reset state
    #2;
    checkOutput("reset_in_ready", {47'b0, in_ready}, 48'd1);
    checkOutput("reset_out_valid", {47'b0, out_valid}, 48'd0);
    checkOutput("reset_product", product, 48'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of MUL (step 2), no clock edge needed
    applyStimulus(24'h123456, 24'hABCDEF);
    void'(expQ.pop_back());
    tick();
    tick();
    checkOutput("mid_mul_in_ready", {47'b0, in_ready}, 48'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_in_ready", {47'b0, in_ready}, 48'd1);
    checkOutput("async_reset_out_valid", {47'b0, out_valid}, 48'd0);
    checkOutput("async_reset_product", product, 48'd0);

    // in_valid held high through reset: capture only after release
    a = 24'h000003;
    b = 24'h000005;
    in_valid = 1'b1;
    tick();
    tick();
    checkOutput("held_reset_out_valid", {47'b0, out_valid}, 48'd0);
    checkOutput("held_reset_product", product, 48'd0);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    expQ.push_back(refMul(24'h000003, 24'h000005));
    waitValid(lat);
    checkOutput("post_reset_latency", 48'(lat), 48'd4);
    checkOutput("post_reset_const", product, 48'h00000000000F);
    completeHandshake("post_reset");

    runDirected("max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    runDirected("zero", 24'h000000, 24'hABCDEF, 48'h000000000000);
    runDirected("hi_only", 24'hFF0000, 24'hFF0000, 48'hFE0100000000);

    // Backpressure with in_valid toggling and fresh operands on the ports
    applyStimulus(24'h800000, 24'hC00000);
    waitValid(lat);
    checkOutput("norm_latency", 48'(lat), 48'd4);
    checkOutput("norm_const", product, 48'h600000000000);
    held = product;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a = 24'($urandom);
      b = 24'($urandom);
      tick();
      checkOutput("bp_product_stable", product, held);
      checkOutput("bp_in_ready_low", {47'b0, in_ready}, 48'd0);
      checkOutput("bp_out_valid_high", {47'b0, out_valid}, 48'd1);
    end
    in_valid = 1'b0;
    completeHandshake("bp");
    tick();
    checkOutput("idle_retains_product", product, 48'h600000000000);
    checkOutput("idle_no_capture", {47'b0, out_valid}, 48'd0);

    // Random soak with idle gaps and random out_ready, including during MUL
    for (int n = 0; n < 3000 && nErrors < 50; n++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom);
        tick();
      end
      out_ready = 1'($urandom);
      ra = 24'($urandom);
      rb = 24'($urandom);
      applyStimulus(ra, rb);
      lat = 0;
      while (!out_valid && lat < 20) begin
        out_ready = 1'($urandom);
        tick();
        lat++;
      end
      checkOutput("soak_latency", 48'(lat), 48'd4);
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        if ($urandom_range(0, 3) != 0) begin
          completeHandshake("soak");
          done = 1'b1;
        end else begin
          out_ready = 1'b0;
          tick();
          checkOutput("soak_hold_valid", {47'b0, out_valid}, 48'd1);
        end
      end
      checkOutput("soak_handshake_done", {47'b0, done}, 48'd1);
    end
    checkOutput("soak_queue_empty", 48'(expQ.size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
